// File: rtl/sc_backg_scheduler_pkg.sv
// Shared definitions for the background-row scheduler: FSM encodings,
// shift-selection codes and the per-row rotation period.
package sc_backg_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4
  } schedState_t;

  localparam logic [1:0] SHIFT_NONE  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  // Rotation period in ticks is (row[1:0]+1) << (3-level), 1..32; the row
  // counters hold period-1 so a 6-bit down-counter is enough.
  function automatic logic [5:0] periodMinusOne(input logic [1:0] rowLsb,
                                                input logic [1:0] level);
    logic [5:0] period;
    period = (6'(rowLsb) + 6'd1) << (2'd3 - level);
    return period - 6'd1;
  endfunction

endpackage

// File: rtl/sc_backg_rowtimer.sv
// Per-row rotation timer: 6-bit down-counter that emits a one-cycle
// shift-selection pulse each time it wraps on a game tick.
module sc_backg_rowtimer
  import sc_backg_scheduler_pkg::*;
(
  input  logic       SC_RegBACKGTYPE_CLOCK_50,
  input  logic       SC_RegBACKGTYPE_RESET_InHigh,
  input  logic       load,
  input  logic       tick,
  input  logic       freeze,
  input  logic       dir,
  input  logic [5:0] periodM1,
  output logic [1:0] shiftSel
);

  logic [5:0] rowCount;

  always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
    if (SC_RegBACKGTYPE_RESET_InHigh) begin
      rowCount <= '0;
      shiftSel <= SHIFT_NONE;
    end else begin
      shiftSel <= SHIFT_NONE;
      if (load) begin
        rowCount <= periodM1;
      end else if (tick && !freeze) begin
        // Reload picks up the level in force now, so a level change lands
        // only at this row's next wrap.
        if (rowCount == 6'd0) begin
          rowCount <= periodM1;
          shiftSel <= dir ? SHIFT_LEFT : SHIFT_RIGHT;
        end else begin
          rowCount <= rowCount - 6'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sc_backg_scheduler.sv
// Background-row sequencer: global clear, row-by-row table load, then
// per-row periodic rotations paced by a prescaled game tick.
module sc_backg_scheduler
  import sc_backg_scheduler_pkg::*;
#(
  parameter int          ROWS     = 8,
  parameter int unsigned PRESCALE = 25'd5000000,
  parameter int          TICK_W   = 25
) (
  input  logic                SC_RegBACKGTYPE_CLOCK_50,
  input  logic                SC_RegBACKGTYPE_RESET_InHigh,
  input  logic                SC_BACKGSCHED_start_InLow,
  input  logic                SC_BACKGSCHED_pause_InLow,
  input  logic [1:0]          SC_BACKGSCHED_level_In,
  input  logic [ROWS-1:0]     SC_BACKGSCHED_dir_In,
  output logic                SC_BACKGSCHED_clear_OutLow,
  output logic [ROWS-1:0]     SC_BACKGSCHED_load_OutLow,
  output logic [3:0]          SC_BACKGSCHED_loadrow_OutBUS,
  output logic [2*ROWS-1:0]   SC_BACKGSCHED_shiftselection_OutBUS,
  output logic [2:0]          SC_BACKGSCHED_state_OutBUS,
  output logic                SC_BACKGSCHED_running_Out
);

  localparam logic [TICK_W-1:0] PRESC_LAST = TICK_W'(PRESCALE - 1);
  localparam logic [3:0]        LAST_ROW   = 4'(ROWS - 1);

  schedState_t       state;
  logic [3:0]        loadIdx;
  logic [ROWS-1:0]   loadN;
  logic              clearN;
  logic              running;
  logic [TICK_W-1:0] prescCount;
  logic              tickP1;
  logic              active;

  // Timing advances only in RUN/PAUSE cycles where neither a restart nor a
  // pause is requested, so the cycle a pause is taken is already frozen.
  assign active = ((state == RUN) || (state == PAUSE)) &&
                  SC_BACKGSCHED_start_InLow && SC_BACKGSCHED_pause_InLow;

  always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
    if (SC_RegBACKGTYPE_RESET_InHigh) begin
      state   <= IDLE;
      clearN  <= 1'b1;
      loadN   <= '1;
      loadIdx <= '0;
      running <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!SC_BACKGSCHED_start_InLow) begin
          state   <= CLEAR;
          clearN  <= 1'b0;
          loadIdx <= '0;
        end
        CLEAR: begin
          state  <= LOAD;
          clearN <= 1'b1;
          loadN  <= ~ROWS'(1);
        end
        LOAD: if (loadIdx == LAST_ROW) begin
          state   <= RUN;
          loadN   <= '1;
          running <= 1'b1;
        end else begin
          loadIdx <= loadIdx + 4'd1;
          loadN   <= ~(ROWS'(1) << (loadIdx + 4'd1));
        end
        RUN, PAUSE: if (!SC_BACKGSCHED_start_InLow) begin
          state   <= CLEAR;
          clearN  <= 1'b0;
          loadIdx <= '0;
          running <= 1'b0;
        end else if (!SC_BACKGSCHED_pause_InLow) begin
          state   <= PAUSE;
          running <= 1'b0;
        end else begin
          state   <= RUN;
          running <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: the tick is registered off the prescaler wrap; it holds while
  // frozen so a tick pending at pause time is consumed on resume.
  always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
    if (SC_RegBACKGTYPE_RESET_InHigh) begin
      prescCount <= '0;
      tickP1     <= 1'b0;
    end else if (state == LOAD) begin
      prescCount <= '0;
      tickP1     <= 1'b0;
    end else if (active) begin
      tickP1     <= (prescCount == PRESC_LAST);
      prescCount <= (prescCount == PRESC_LAST) ? '0 : prescCount + TICK_W'(1);
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : gRow
    localparam logic [3:0] ROW_IDX = 4'(r);
    sc_backg_rowtimer uRowTimer (
      .SC_RegBACKGTYPE_CLOCK_50     (SC_RegBACKGTYPE_CLOCK_50),
      .SC_RegBACKGTYPE_RESET_InHigh (SC_RegBACKGTYPE_RESET_InHigh),
      .load     ((state == LOAD) && (loadIdx == ROW_IDX)),
      .tick     (tickP1),
      .freeze   (!active),
      .dir      (SC_BACKGSCHED_dir_In[r]),
      .periodM1 (periodMinusOne(ROW_IDX[1:0], SC_BACKGSCHED_level_In)),
      .shiftSel (SC_BACKGSCHED_shiftselection_OutBUS[2*r+1:2*r])
    );
  end

  assign SC_BACKGSCHED_clear_OutLow   = clearN;
  assign SC_BACKGSCHED_load_OutLow    = loadN;
  assign SC_BACKGSCHED_loadrow_OutBUS = loadIdx;
  assign SC_BACKGSCHED_state_OutBUS   = state;
  assign SC_BACKGSCHED_running_Out    = running;

endmodule
